// File: rtl/seq_mul_add_if.sv
// ============================================================================
// Module   : seq_mul_add_if
// Brief    : Start/valid operand and result bundle for seq_mul_add.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seq_mul_add_if #(
    parameter int WIDTH = 16
) ();
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic [WIDTH-1:0]       addend;
    logic [2*WIDTH-1:0]     expected;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;
    logic                   valid;
    logic                   match;

    modport master (
        output start, multiplicand, multiplier, addend, expected,
        input  product, busy, valid, match
    );

    modport slave (
        input  start, multiplicand, multiplier, addend, expected,
        output product, busy, valid, match
    );
endinterface

`default_nettype wire

// File: rtl/seq_mul_add.sv
// ============================================================================
// Module   : seq_mul_add
// Brief    : Shift-add multiply-accumulate, product = A*B + C, fixed WIDTH-cycle latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_mul_add #(
    parameter int WIDTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    seq_mul_add_if.slave    bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_exp;
    logic [CW-1:0]      r_cnt;
    logic [PW-1:0]      r_product;
    logic               r_busy;
    logic               r_valid;
    logic               r_match;

    state_t             w_state_nxt;
    logic [PW-1:0]      w_mcand_nxt;
    logic [WIDTH-1:0]   w_mplr_nxt;
    logic [PW-1:0]      w_acc_nxt;
    logic [PW-1:0]      w_exp_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [PW-1:0]      w_product_nxt;
    logic               w_busy_nxt;
    logic               w_valid_nxt;
    logic               w_match_nxt;
    logic [PW-1:0]      w_acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_exp     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplr    <= w_mplr_nxt;
            r_acc     <= w_acc_nxt;
            r_exp     <= w_exp_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
            r_busy    <= w_busy_nxt;
            r_valid   <= w_valid_nxt;
            r_match   <= w_match_nxt;
        end
    end

    // Partial product for the current multiplier bit; final iteration's sum is the result.
    assign w_acc_sum = r_acc + (r_mplr[0] ? r_mcand : '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_mplr_nxt    = r_mplr;
        w_acc_nxt     = r_acc;
        w_exp_nxt     = r_exp;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        w_busy_nxt    = r_busy;
        w_valid_nxt   = r_valid;
        w_match_nxt   = r_match;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_mcand_nxt = {{WIDTH{1'b0}}, bus.multiplicand};
                    w_mplr_nxt  = bus.multiplier;
                    w_acc_nxt   = {{WIDTH{1'b0}}, bus.addend};
                    w_exp_nxt   = bus.expected;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_match_nxt = 1'b0;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_acc_nxt   = w_acc_sum;
                w_mcand_nxt = r_mcand << 1;
                w_mplr_nxt  = r_mplr >> 1;
                w_cnt_nxt   = r_cnt + CW'(1);
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt     = '0;
                    w_product_nxt = w_acc_sum;
                    w_match_nxt   = (w_acc_sum == r_exp);
                    w_busy_nxt    = 1'b0;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.product = r_product;
    assign bus.busy    = r_busy;
    assign bus.valid   = r_valid;
    assign bus.match   = r_match;

endmodule

`default_nettype wire

// File: tb/tb_seq_mul_add.sv
// ============================================================================
// Module   : tb_seq_mul_add
// Brief    : Scoreboard bench for seq_mul_add with directed vectors and divider round-trip.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_mul_add;
    logic clk;
    logic rst;

    seq_mul_add_if #(.WIDTH(16)) bus ();

    seq_mul_add #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] p;
        logic        m;
    } exp_t;

    exp_t        sb_q[$];
    int          tests;
    int          fails;
    logic [31:0] last_product;
    logic        prev_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pops one expected result on every rising edge of valid.
    initial begin
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                tests++;
                if (!bus.valid && bus.match) begin
                    fails++;
                    $display("FAIL match_qual: got match=%0b with valid=0, required 0", bus.match);
                end
                if (bus.valid && !prev_valid) begin
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got product=%h, required no result", bus.product);
                    end else begin
                        e = sb_q.pop_front();
                        tests += 2;
                        if (bus.product !== e.p) begin
                            fails++;
                            $display("FAIL sb_product: got %h, required %h", bus.product, e.p);
                        end
                        if (bus.match !== e.m) begin
                            fails++;
                            $display("FAIL sb_match: got %0b, required %0b", bus.match, e.m);
                        end
                    end
                end
                prev_valid = bus.valid;
            end
        end
    end

    // Drives one start pulse; returns just after the acceptance edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [31:0] e);
        @(negedge clk);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.addend       = c;
        bus.expected     = e;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.multiplicand = 16'hDEAD;
        bus.multiplier   = 16'hBEEF;
        bus.addend       = 16'h5A5A;
        bus.expected     = 32'hFFFF_FFFF;
        chk("accept_busy",  {31'b0, bus.busy},  32'd1);
        chk("accept_valid", {31'b0, bus.valid}, 32'd0);
        chk("accept_match", {31'b0, bus.match}, 32'd0);
        chk("accept_product_held", bus.product, last_product);
    endtask

    // Waits for valid, counting edges after acceptance; first already-spent edges given.
    task automatic wait_result(input int spent, input logic [31:0] ep);
        int n;
        n = spent;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.valid) break;
        end
        chk("latency", n, 32'd16);
        chk("done_busy", {31'b0, bus.busy}, 32'd0);
        last_product = ep;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [31:0] e, input logic [31:0] ep, input logic em);
        exp_t x;
        x.p = ep;
        x.m = em;
        sb_q.push_back(x);
        issue(a, b, c, e);
        wait_result(0, ep);
    endtask

    initial begin
        logic [15:0] dvd, dvs, q, r;
        tests        = 0;
        fails        = 0;
        last_product = 32'd0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.addend       = '0;
        bus.expected     = '0;
        rst = 1'b1;
        #1;
        chk("reset_product", bus.product, 32'd0);
        chk("reset_busy",    {31'b0, bus.busy},  32'd0);
        chk("reset_valid",   {31'b0, bus.valid}, 32'd0);
        chk("reset_match",   {31'b0, bus.match}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic, then hold check
        run(16'd7, 16'd9, 16'd5, 32'd68, 32'd68, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_valid",   {31'b0, bus.valid}, 32'd1);
        chk("hold_product", bus.product, 32'd68);
        chk("hold_match",   {31'b0, bus.match}, 32'd1);

        // Max values
        run(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000, 32'hFFFF_0000, 1'b1);

        // Zero multiplier: no early termination, mismatch expected
        run(16'd1234, 16'd0, 16'd99, 32'd100, 32'd99, 1'b0);

        // Start during busy is ignored
        begin
            exp_t x;
            x.p = 32'd13;
            x.m = 1'b1;
            sb_q.push_back(x);
        end
        issue(16'd3, 16'd4, 16'd1, 32'd13);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.multiplicand = 16'd10;
        bus.multiplier   = 16'd10;
        bus.addend       = 16'd0;
        bus.expected     = 32'd100;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ignored_busy", {31'b0, bus.busy}, 32'd1);
        wait_result(6, 32'd13);
        repeat (20) @(posedge clk);
        #1;
        chk("no_second_valid",   {31'b0, bus.valid}, 32'd1);
        chk("no_second_product", bus.product, 32'd13);
        chk("no_second_busy",    {31'b0, bus.busy},  32'd0);
        run(16'd10, 16'd10, 16'd0, 32'd100, 32'd100, 1'b1);

        // Reset mid-operation
        issue(16'd300, 16'd200, 16'd1, 32'd60001);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_product", bus.product, 32'd0);
        chk("midrst_busy",    {31'b0, bus.busy},  32'd0);
        chk("midrst_valid",   {31'b0, bus.valid}, 32'd0);
        chk("midrst_match",   {31'b0, bus.match}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_product = 32'd0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_valid", {31'b0, bus.valid}, 32'd0);
        run(16'd2, 16'd3, 16'd1, 32'd7, 32'd7, 1'b1);

        // Divider round-trip: dividend = quotient*divisor + remainder
        for (int k = 0; k < 1000; k++) begin
            dvd = 16'($urandom_range(0, 65535));
            dvs = (k % 2 == 1) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            q   = dvd / dvs;
            r   = dvd % dvs;
            run(q, dvs, r, {16'b0, dvd}, {16'b0, dvd}, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/seq_mul_add.md
Name: seq_mul_add

Overview:
- Sequential shift-add multiply-accumulate unit computing product = multiplicand * multiplier + addend.
- Inverse partner of the restoring divider. Given quotient, divisor and remainder, it rebuilds the dividend in hardware.
- Used by the divider's on-board self-check path. Also usable as a general multiplier.
- Uses the same start/valid handshake style as the divider.

Parameters:
- WIDTH, 16, operand width in bits. Product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled only when busy=0.
- multiplicand  input  WIDTH  operand A (e.g. quotient).
- multiplier  input  WIDTH  operand B (e.g. divisor).
- addend  input  WIDTH  value added to the product (e.g. remainder).
- expected  input  2*WIDTH  reference value for the match check (e.g. zero-extended dividend).
- product  output  2*WIDTH  registered result of the last completed operation.
- busy  output  1  high while computing.
- valid  output  1  high when product holds a completed result.
- match  output  1  high when product == expected, qualified by valid.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, product=0, busy=0, valid=0, match=0, internal accumulator, shift registers and counter all 0. Takes effect immediately, including mid-operation; the aborted operation produces no result.
- States are IDLE, CALC and DONE.
- IDLE or DONE with start=1 at a rising edge (acceptance edge E0):
  - latch multiplicand zero-extended to 2*WIDTH into a left-shift register;
  - latch multiplier into a right-shift register;
  - set accumulator = zero-extended addend; latch expected;
  - counter=0; busy=1; valid=0; match=0; go to CALC.
- CALC, each edge:
  - if multiplier-register LSB=1, accumulator += multiplicand register;
  - then shift the multiplicand register left 1 and the multiplier register right 1;
  - counter increments.
- CALC exit: on the edge where counter==WIDTH-1, the final iteration completes. On that same edge:
  - product = final accumulator, match = (final accumulator == latched expected);
  - busy=0, valid=1, go to DONE.
- Fixed latency: valid is first high after edge E0+WIDTH (16 cycles at the default). There is no early termination, even when the multiplier is 0.
- DONE holds product, valid and match until the next accepted start. The acceptance edge clears valid and match; product keeps its old value until the new result is written.
- start while busy=1 is ignored; operands and state are unaffected. start held high continuously re-launches an operation every WIDTH+1 cycles.
- Input operands may change freely after the acceptance edge; only latched copies are used.
- Arithmetic is unsigned. Maximum result (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W fits in 2*WIDTH bits, so no overflow is possible and no carry-out is kept.
- The accumulator adder width is 2*WIDTH.
- match is 0 whenever valid=0.

Test Plan:
- Basic: multiplicand=7, multiplier=9, addend=5, expected=68, start for 1 cycle -> busy for 16 cycles. Then valid=1, product=68, match=1, held until next start.
- Max values: multiplicand=multiplier=addend=0xFFFF, expected=0xFFFF0000 -> product=0xFFFF0000, match=1, latency exactly 16 cycles.
- Zero operand: multiplicand=1234, multiplier=0, addend=99, expected=100 -> product=99, match=0, valid=1 still after 16 cycles.
- Ignored start: launch 3*4+1, pulse start with 10*10+0 at cycle 5 of CALC -> product=13 at the normal time, no second result. A later start with busy=0 then produces 100.
- Reset mid-operation: launch 300*200+1, assert rst at cycle 8 -> outputs 0 immediately, valid never rises. After release, a new start 2*3+1 gives product=7 after 16 cycles.
- Divider round-trip: sweep 1000 random (dividend, divisor≠0) pairs through the divider. Feed quotient, divisor, remainder and the dividend into this block -> match=1 on every result.
